// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: walks each instruction through FETCH, DECODE,
// EXEC, MEM and WB and drives the PC, IR, register-file, ALU and memory
// request controls. Memory waits are bounded by MEM_TIMEOUT (0 = unbounded).
// Optional macro MULTICYCLE_CTRL_PERF_EN adds retire and stall counters.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [3:0] alu_op,
  output logic       alu_src_imm,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       rf_we,
  output logic       wb_from_mem,
  output logic       retire,
  output logic       halted,
  output logic       illegal_op,
  output logic       bus_error
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
`endif
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  localparam logic [3:0] OP_ADDI  = 4'd6;
  localparam logic [3:0] OP_LOAD  = 4'd7;
  localparam logic [3:0] OP_STORE = 4'd8;
  localparam logic [3:0] OP_BEQ   = 4'd9;
  localparam logic [3:0] OP_JUMP  = 4'd10;
  localparam logic [3:0] OP_NOP   = 4'd11;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5,
    TRAP   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q;
  logic [WAIT_W-1:0] wait_q;
  logic              wait_expired;
  logic              set_halt, set_illegal, set_bus;

  assign wait_expired = TIMEOUT_EN && (wait_q == WAIT_LAST);

  // Next-state and control outputs; reset forces every output quiet so an
  // aborted instruction produces no stray pulse.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    alu_op      = 4'd0;
    alu_src_imm = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    wb_from_mem = 1'b0;
    retire      = 1'b0;
    set_halt    = 1'b0;
    set_illegal = 1'b0;
    set_bus     = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        // A ready in the timeout cycle still wins.
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (wait_expired) begin
          set_bus = 1'b1;
          state_d = TRAP;
        end
      end
      DECODE: begin
        pc_we = 1'b1;
        case (opcode)
          OP_HALT: begin
            set_halt = 1'b1;
            state_d  = HALTED;
          end
          4'd12, 4'd13, 4'd14: begin
            set_illegal = 1'b1;
            state_d     = TRAP;
          end
          OP_NOP: begin
            retire  = 1'b1;
            state_d = FETCH;
          end
          default: state_d = EXEC;
        endcase
      end
      EXEC: begin
        alu_op      = op_q;
        alu_src_imm = (op_q inside {OP_ADDI, OP_LOAD, OP_STORE});
        case (op_q)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, OP_ADDI: state_d = WB;
          OP_LOAD, OP_STORE: state_d = MEM;
          OP_BEQ: begin
            // Offset is relative to PC+1, already written in DECODE.
            if (branch_taken) begin
              pc_we  = 1'b1;
              pc_sel = 2'b01;
            end
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_JUMP: begin
            pc_we   = 1'b1;
            pc_sel  = 2'b10;
            retire  = 1'b1;
            state_d = FETCH;
          end
          default: state_d = TRAP;
        endcase
      end
      MEM: begin
        dmem_req    = 1'b1;
        dmem_we     = (op_q == OP_STORE);
        alu_src_imm = 1'b1;
        if (dmem_ready) begin
          if (op_q == OP_STORE) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (wait_expired) begin
          set_bus = 1'b1;
          state_d = TRAP;
        end
      end
      WB: begin
        rf_we       = 1'b1;
        wb_from_mem = (op_q == OP_LOAD);
        retire      = 1'b1;
        state_d     = FETCH;
      end
      HALTED, TRAP: state_d = state_q;
      default: state_d = TRAP;
    endcase
    if (reset) begin
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 2'b00;
      alu_op      = 4'd0;
      alu_src_imm = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      rf_we       = 1'b0;
      wb_from_mem = 1'b0;
      retire      = 1'b0;
      set_halt    = 1'b0;
      set_illegal = 1'b0;
      set_bus     = 1'b0;
    end
  end

  // State register, latched opcode and memory wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= 4'd0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
      // Counts consecutive wait cycles; any state change restarts it.
      if ((state_d == state_q) && ((state_q == FETCH) || (state_q == MEM)))
        wait_q <= wait_q + WAIT_W'(1);
      else
        wait_q <= '0;
    end
  end

  // Sticky status flags; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted     <= 1'b0;
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      if (set_halt)    halted     <= 1'b1;
      if (set_illegal) illegal_op <= 1'b1;
      if (set_bus)     bus_error  <= 1'b1;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic stall;
  assign stall = ((state_q == FETCH) && !imem_ready) || ((state_q == MEM) && !dmem_ready);

  // Performance counters; terminal states never retire or stall, so they freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (retire) instr_count <= instr_count + CNT_W'(1);
      if (stall)  stall_count <= stall_count + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the 32-bit ISA: 4-bit opcode, three 5-bit register fields, 13-bit offset.
- Consumes the opcode from the instruction decoder and sequences fetch, decode, execute, memory and writeback over successive cycles.
- Drives PC, IR, register-file, ALU and memory-request controls.
- Handles ready/request handshakes to instruction and data memory, with a wait timeout.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles spent in FETCH or MEM waiting for ready before trapping; 0 disables the timeout.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- opcode  in  4  opcode field from the decoder; valid from the DECODE state onward.
- branch_taken  in  1  ALU equality result; sampled in EXEC for BEQ only.
- imem_ready  in  1  instruction memory has data this cycle.
- dmem_ready  in  1  data memory completed the access this cycle.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  load the instruction register.
- pc_we  out  1  PC write enable.
- pc_sel  out  2  PC source: 00 = PC+1, 01 = PC+sign-extended offset, 10 = offset (jump).
- alu_op  out  4  ALU operation; equals the latched opcode in EXEC, else 0.
- alu_src_imm  out  1  ALU operand B is the sign-extended offset.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (STORE).
- rf_we  out  1  register-file write to reg_d.
- wb_from_mem  out  1  writeback data comes from memory rather than the ALU.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  sticky; HALT executed.
- illegal_op  out  1  sticky; undefined opcode trapped.
- bus_error  out  1  sticky; memory wait timeout.

Behaviour:
- Opcode map:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT: R-type.
  - 6 ADDI, 7 LOAD, 8 STORE, 9 BEQ, 10 JUMP, 11 NOP, 15 HALT.
  - 12–14 are illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, HALTED, TRAP; 3-bit encoding; reset state is FETCH.
- Reset values: all outputs 0. Internal registers reset to 0: latched opcode op_q, wait counter, sticky flags. Reset mid-instruction aborts it with no pulse on any output in the reset cycle.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_we=1 in the same cycle (combinational), then go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE:
  - op_q <= opcode; pc_we=1 with pc_sel=00.
  - Next state:
    - HALT -> HALTED.
    - Illegal opcode -> TRAP with illegal_op set.
    - NOP -> FETCH with retire=1.
    - Anything else -> EXEC.
- EXEC:
  - alu_op=op_q; alu_src_imm=1 for ADDI, LOAD and STORE.
  - R-type and ADDI -> WB.
  - LOAD and STORE -> MEM.
  - BEQ: if branch_taken, pc_we=1 with pc_sel=01. Then go to FETCH with retire=1.
  - JUMP: pc_we=1 with pc_sel=10, then go to FETCH with retire=1.
- MEM:
  - dmem_req=1; dmem_we=(op_q==STORE); alu_src_imm=1 is held.
  - On dmem_ready=1: LOAD -> WB; STORE -> FETCH with retire=1.
- WB: rf_we=1; wb_from_mem=(op_q==LOAD); go to FETCH with retire=1.
- Wait counter:
  - Cleared on every entry to FETCH or MEM.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT-1 with ready still low, go to TRAP and set bus_error.
  - A ready arriving in the same cycle as the timeout wins: normal progress, no trap.
- HALTED and TRAP are terminal. All request and enable outputs are 0 in these states; only reset exits them.
- The PC+1 write happens in DECODE, so PC+offset in EXEC is relative to the next instruction.
- Latency with zero-wait memory (FETCH through retire):
  - R-type/ADDI: 4 cycles. LOAD: 5. STORE: 4. BEQ/JUMP: 3. NOP: 2.
  - Each wait cycle adds 1.
- retire asserts in the last cycle of the instruction, in the same cycle as any pc_we or rf_we of that state.

Optional Feature:
- Macro MULTICYCLE_CTRL_PERF_EN.
- When defined, the block adds outputs instr_count[CNT_W-1:0] and stall_count[CNT_W-1:0]:
  - instr_count increments on every retire.
  - stall_count increments on every FETCH or MEM cycle whose ready is low.
  - Both are cleared by reset, wrap at 2^CNT_W, and freeze in HALTED/TRAP.
- When undefined, neither the ports nor the logic exist.

Test Plan:
- Reset, then ADD (opcode 0) with imem_ready and dmem_ready tied 1 -> FETCH/DECODE/EXEC/WB. rf_we=1 and retire=1 in cycle 4 only; alu_op=0 in cycle 3.
- LOAD with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0. WB has rf_we=1 and wb_from_mem=1. Total 8 cycles.
- BEQ, once with branch_taken=1 and once with 0:
  - Taken: pc_we in DECODE (sel 00) and in EXEC (sel 01); retire in cycle 3.
  - Not taken: pc_we in DECODE only.
- Opcode 13 -> TRAP entered after DECODE; illegal_op=1 sticky; imem_req stays 0 for 10 further cycles. Reset clears it.
- imem_ready held 0 with MEM_TIMEOUT=16 -> bus_error=1 after 16 FETCH cycles. Repeat with ready arriving on cycle 16 -> no trap.
- HALT, then reset asserted mid-LOAD (in MEM) -> halted=1 after DECODE; reset returns all outputs to 0. With MULTICYCLE_CTRL_PERF_EN defined, instr_count matches the number of retire pulses.
